// File: rtl/mem_bank.sv
// mem_bank: dual-port SRAM bank. Port A is a read/write data port with byte
// enables; port B is a read-only fetch port. After reset a clear sequencer
// zero-fills the array (optional) before any request is granted.
//
// Handshake: a request is accepted in the same cycle it is presented
// (gnt = req & init_done, no backpressure once running). Every accepted
// request, read or write, returns exactly one rvalid pulse, in order,
// READ_LATENCY cycles after its grant. rdata changes only on a read response
// and holds its value otherwise. Reset drops any responses still in flight.
module mem_bank #(
   parameter int ADDR_WIDTH    = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int READ_LATENCY  = 1,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    init_done,
   input  logic                    a_req,
   input  logic                    a_we,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic [DATA_WIDTH-1:0]   a_wdata,
   output logic                    a_gnt,
   output logic                    a_rvalid,
   output logic [DATA_WIDTH-1:0]   a_rdata,
   input  logic                    b_req,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   output logic                    b_gnt,
   output logic                    b_rvalid,
   output logic [DATA_WIDTH-1:0]   b_rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int NBE   = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic CLEAR_EN = (INIT_ON_RESET != 0);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic                    r_init_done;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    r_a_v1;
   logic [DATA_WIDTH-1:0]   r_a_d1;
   logic                    r_b_v1;
   logic [DATA_WIDTH-1:0]   r_b_d1;

   logic                    w_a_gnt;
   logic                    w_b_gnt;
   logic                    w_a_wr;
   logic                    w_clr_we;

   assign w_a_gnt   = a_req & r_init_done;
   assign w_b_gnt   = b_req & r_init_done;
   assign a_gnt     = w_a_gnt;
   assign b_gnt     = w_b_gnt;
   assign init_done = r_init_done;

   // A write that lands on a reset edge is discarded along with its response.
   assign w_a_wr   = w_a_gnt & a_we & ~reset;
   assign w_clr_we = (r_state == ST_CLEAR) & CLEAR_EN & ~reset;

   // Clear sequencer: walk the pointer over every word, then enter RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_CLEAR;
         r_ptr       <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (!CLEAR_EN || r_ptr == PTR_LAST) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
               if (CLEAR_EN) r_ptr <= r_ptr + PTR_ONE;
            end
            ST_RUN: begin
               r_init_done <= 1'b1;
            end
            default: begin
               r_state     <= ST_CLEAR;
               r_init_done <= 1'b0;
            end
         endcase
      end
   end

   // Array write: clear zero-fill during CLEAR, byte-masked port A writes in RUN.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_ptr] <= '0;
      end else if (w_a_wr) begin
         for (int i = 0; i < NBE; i++) begin
            if (a_be[i]) r_mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
         end
      end
   end

   // First response stage: sample the array on grant (old data on same-edge write).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a_v1 <= 1'b0;
         r_a_d1 <= '0;
         r_b_v1 <= 1'b0;
         r_b_d1 <= '0;
      end else begin
         r_a_v1 <= w_a_gnt;
         if (w_a_gnt && !a_we) r_a_d1 <= r_mem[a_addr];
         r_b_v1 <= w_b_gnt;
         if (w_b_gnt) r_b_d1 <= r_mem[b_addr];
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_a_v2;
      logic [DATA_WIDTH-1:0] r_a_d2;
      logic                  r_b_v2;
      logic [DATA_WIDTH-1:0] r_b_d2;

      // Second response stage: plain valid/data register behind stage one.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_a_v2 <= 1'b0;
            r_a_d2 <= '0;
            r_b_v2 <= 1'b0;
            r_b_d2 <= '0;
         end else begin
            r_a_v2 <= r_a_v1;
            if (r_a_v1) r_a_d2 <= r_a_d1;
            r_b_v2 <= r_b_v1;
            if (r_b_v1) r_b_d2 <= r_b_d1;
         end
      end

      assign a_rvalid = r_a_v2;
      assign a_rdata  = r_a_d2;
      assign b_rvalid = r_b_v2;
      assign b_rdata  = r_b_d2;
   end else begin : g_lat1
      assign a_rvalid = r_a_v1;
      assign a_rdata  = r_a_d1;
      assign b_rvalid = r_b_v1;
      assign b_rdata  = r_b_d1;
   end

endmodule

// File: tb/tb_mem_bank.sv
// Bench for mem_bank: instance 0 is READ_LATENCY=1 with clear enabled,
// instance 1 is READ_LATENCY=2 with clear disabled. Requests push expected
// responses (data plus arrival cycle) into a queue; a negedge monitor pops.
module tb_mem_bank;
   localparam int AW  = 4;
   localparam int DW  = 32;
   localparam int NBE = 4;

   typedef struct {
      int              ch;
      logic [DW-1:0]   data;
      int              cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic            rst       [2];
   logic            init_done [2];
   logic            a_req     [2];
   logic            a_we      [2];
   logic [AW-1:0]   a_addr    [2];
   logic [NBE-1:0]  a_be      [2];
   logic [DW-1:0]   a_wdata   [2];
   logic            a_gnt     [2];
   logic            a_rvalid  [2];
   logic [DW-1:0]   a_rdata   [2];
   logic            b_req     [2];
   logic [AW-1:0]   b_addr    [2];
   logic            b_gnt     [2];
   logic            b_rvalid  [2];
   logic [DW-1:0]   b_rdata   [2];

   int            lat    [2];
   logic [DW-1:0] a_last [2];
   string         ch_name [4];
   exp_t          exp_q [$];
   int            n_checks = 0;
   int            n_pass   = 0;

   mem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .INIT_ON_RESET(1)) u_dut0 (
      .clk(clk), .reset(rst[0]), .init_done(init_done[0]),
      .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_be(a_be[0]),
      .a_wdata(a_wdata[0]), .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
      .b_req(b_req[0]), .b_addr(b_addr[0]), .b_gnt(b_gnt[0]),
      .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0])
   );

   mem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .INIT_ON_RESET(0)) u_dut1 (
      .clk(clk), .reset(rst[1]), .init_done(init_done[1]),
      .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_be(a_be[1]),
      .a_wdata(a_wdata[1]), .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
      .b_req(b_req[1]), .b_addr(b_addr[1]), .b_gnt(b_gnt[1]),
      .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1])
   );

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Pop the oldest expectation for this channel and compare data and arrival cycle.
   task automatic match(input int ch, input logic [DW-1:0] got);
      int idx;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].ch == ch) begin
            idx = i;
            break;
         end
      end
      n_checks++;
      if (idx < 0) begin
         $display("FAIL rvalid_%s: unexpected response data %h at cycle %0d", ch_name[ch], got, cyc);
      end else begin
         if (got === exp_q[idx].data && cyc == exp_q[idx].cyc) n_pass++;
         else $display("FAIL rdata_%s: got %h at cycle %0d expected %h at cycle %0d",
                       ch_name[ch], got, cyc, exp_q[idx].data, exp_q[idx].cyc);
         exp_q.delete(idx);
      end
   endtask

   // Monitor: every rvalid seen away from the active edge is scored.
   always @(negedge clk) begin
      if (a_rvalid[0] === 1'b1) match(0, a_rdata[0]);
      if (b_rvalid[0] === 1'b1) match(1, b_rdata[0]);
      if (a_rvalid[1] === 1'b1) match(2, a_rdata[1]);
      if (b_rvalid[1] === 1'b1) match(3, b_rdata[1]);
   end

   // One cycle of stimulus on both ports of instance d; expectations pushed on issue.
   task automatic drive(input int d,
                        input bit ar, input bit awe, input logic [AW-1:0] aad,
                        input logic [NBE-1:0] abe, input logic [DW-1:0] awd, input logic [DW-1:0] aexp,
                        input bit br, input logic [AW-1:0] bad, input logic [DW-1:0] bexp);
      exp_t e;
      @(negedge clk);
      a_req[d] = ar; a_we[d] = awe; a_addr[d] = aad; a_be[d] = abe; a_wdata[d] = awd;
      b_req[d] = br; b_addr[d] = bad;
      if (ar) begin
         e.ch  = 2 * d;
         e.cyc = cyc + lat[d];
         if (awe) begin
            e.data = a_last[d];
         end else begin
            e.data    = aexp;
            a_last[d] = aexp;
         end
         exp_q.push_back(e);
      end
      if (br) begin
         e.ch   = 2 * d + 1;
         e.cyc  = cyc + lat[d];
         e.data = bexp;
         exp_q.push_back(e);
      end
      #1;
      if (ar) check($sformatf("a_gnt_%0d", d), {31'b0, a_gnt[d]}, 32'd1);
      if (br) check($sformatf("b_gnt_%0d", d), {31'b0, b_gnt[d]}, 32'd1);
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      a_req[d] = 1'b0; a_we[d] = 1'b0; b_req[d] = 1'b0;
   endtask

   // Called on the negedge reset is released: requests stay blocked for n edges.
   task automatic clear_check(input int d, input int n);
      a_req[d] = 1'b1; a_we[d] = 1'b0; b_req[d] = 1'b1;
      for (int k = 0; k < n; k++) begin
         #1;
         check($sformatf("init_done_low_%0d", d), {31'b0, init_done[d]}, 32'd0);
         check($sformatf("a_gnt_blocked_%0d", d), {31'b0, a_gnt[d]}, 32'd0);
         check($sformatf("b_gnt_blocked_%0d", d), {31'b0, b_gnt[d]}, 32'd0);
         @(negedge clk);
      end
      a_req[d] = 1'b0; b_req[d] = 1'b0;
      #1;
      check($sformatf("init_done_high_%0d", d), {31'b0, init_done[d]}, 32'd1);
   endtask

   initial begin
      lat[0] = 1; lat[1] = 2;
      ch_name[0] = "a0"; ch_name[1] = "b0"; ch_name[2] = "a1"; ch_name[3] = "b1";
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; a_req[d] = 1'b0; a_we[d] = 1'b0; a_addr[d] = '0; a_be[d] = '0;
         a_wdata[d] = '0; b_req[d] = 1'b0; b_addr[d] = '0; a_last[d] = '0;
      end
      repeat (3) @(negedge clk);

      // ---------- instance 0: latency 1, clear enabled ----------
      rst[0] = 1'b0;
      clear_check(0, 16);
      for (int i = 0; i < 16; i++) drive(0, 1, 1, AW'(i), 4'hF, 32'hFFFF_FFFF, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 4'd0, 32'hFFFF_FFFF);
      idle(0);
      @(negedge clk); rst[0] = 1'b1; a_last[0] = '0;
      @(negedge clk); rst[0] = 1'b0;
      clear_check(0, 16);
      for (int i = 0; i < 16; i++) drive(0, 1, 0, AW'(15 - i), 0, 0, 32'h0, 1, AW'(i), 32'h0);
      // byte enables: be=0101 merges bytes 0 and 2 of the second word
      drive(0, 1, 1, 4'd3, 4'hF, 32'h1122_3344, 0, 0, 0, 0);
      drive(0, 1, 1, 4'd3, 4'b0101, 32'hAABB_CCDD, 0, 0, 0, 0);
      drive(0, 1, 0, 4'd3, 0, 0, 32'h11BB_33DD, 1, 4'd3, 32'h11BB_33DD);
      // same-cycle collision: B sees old word, next read sees new word
      drive(0, 1, 1, 4'd5, 4'hF, 32'h0000_0001, 0, 0, 0, 0);
      drive(0, 1, 1, 4'd5, 4'hF, 32'hDEAD_BEEF, 0, 1, 4'd5, 32'h0000_0001);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 32'hDEAD_BEEF);
      // reset mid-operation: reads presented on the reset edge must never respond
      drive(0, 1, 0, 4'd3, 0, 0, 32'h11BB_33DD, 1, 4'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 4'd5; b_req[0] = 1'b1; b_addr[0] = 4'd3;
      rst[0] = 1'b1; a_last[0] = '0;
      @(negedge clk);
      rst[0] = 1'b0; a_req[0] = 1'b0; b_req[0] = 1'b0;
      #1;
      check("a_rvalid_after_reset", {31'b0, a_rvalid[0]}, 32'd0);
      check("b_rvalid_after_reset", {31'b0, b_rvalid[0]}, 32'd0);
      check("a_rdata_after_reset", a_rdata[0], 32'h0);
      check("b_rdata_after_reset", b_rdata[0], 32'h0);
      clear_check(0, 16);
      drive(0, 1, 0, 4'd3, 0, 0, 32'h0, 1, 4'd5, 32'h0);
      idle(0);

      // ---------- instance 1: latency 2, clear disabled ----------
      @(negedge clk); rst[1] = 1'b0;
      clear_check(1, 1);
      for (int i = 0; i < 8; i++) drive(1, 1, 1, AW'(i), 4'hF, 32'(i * 3), 0, 0, 0, 0);
      drive(1, 1, 0, 4'd7, 0, 0, 32'd21, 0, 0, 0);
      // write response keeps a_rdata at 21
      drive(1, 1, 1, 4'd9, 4'hF, 32'h55, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, AW'(i), 32'(i * 3));
      drive(1, 1, 1, 4'd5, 4'hF, 32'hDEAD_BEEF, 0, 1, 4'd5, 32'd15);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 4'd5, 32'hDEAD_BEEF);
      drive(1, 1, 1, 4'd3, 4'hF, 32'h1122_3344, 0, 0, 0, 0);
      drive(1, 1, 1, 4'd3, 4'b0101, 32'hAABB_CCDD, 0, 0, 0, 0);
      drive(1, 1, 0, 4'd9, 0, 0, 32'h55, 1, 4'd3, 32'h11BB_33DD);
      // contents survive reset when the clear is disabled
      drive(1, 1, 1, 4'd2, 4'hF, 32'h1234_5678, 0, 0, 0, 0);
      idle(1);
      repeat (2) @(negedge clk);
      rst[1] = 1'b1; a_last[1] = '0;
      @(negedge clk); rst[1] = 1'b0;
      clear_check(1, 1);
      drive(1, 1, 0, 4'd3, 0, 0, 32'h11BB_33DD, 1, 4'd2, 32'h1234_5678);
      idle(1);
      repeat (4) @(negedge clk);

      check("responses_outstanding", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_bank.md
# mem_bank

Parametrised dual-port SRAM bank for the core's instruction and data memories. Replaces the single-port enable/write memory model. Port A is a read/write data port with byte enables. Port B is a read-only fetch port. Both use a req/gnt/rvalid handshake, have a configurable read latency, and share a hardware clear sequencer that zero-fills the array after reset.

## Interface
- ADDR_WIDTH, default 10: word address width; DEPTH = 1<<ADDR_WIDTH words.
- DATA_WIDTH, default 32: word width; must be a multiple of 8. NBE = DATA_WIDTH/8.
- READ_LATENCY, default 1: 1 or 2 cycles from grant to rvalid. Value 2 adds an output register stage.
- INIT_ON_RESET, default 1: 1 zero-fills the array after reset; 0 skips the clear.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init_done  out  1  array ready; grants are blocked while 0.
- a_req  in  1  port A request.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  word address.
- a_be  in  NBE  byte enables; used only on writes.
- a_wdata  in  DATA_WIDTH  write data.
- a_gnt  out  1  request accepted this cycle (combinational).
- a_rvalid  out  1  response for an accepted request.
- a_rdata  out  DATA_WIDTH  read data.
- b_req  in  1  port B read request.
- b_addr  in  ADDR_WIDTH  word address.
- b_gnt  out  1  request accepted this cycle (combinational).
- b_rvalid  out  1  response for an accepted read.
- b_rdata  out  DATA_WIDTH  read data.

## Operation
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: init_done=0; a_rvalid=b_rvalid=0; a_rdata=b_rdata=0; all pipeline valid bits cleared; clear pointer=0; FSM=CLEAR.
- FSM states: CLEAR and RUN.
- CLEAR state:
  - Each non-reset cycle writes all-zero to MEM[ptr], then ptr increments.
  - When ptr==DEPTH-1 has been written, next state is RUN.
  - If INIT_ON_RESET=0, CLEAR lasts exactly one cycle and writes nothing.
- RUN state: init_done=1; stays in RUN until reset.
- Grants: a_gnt = a_req & init_done; b_gnt = b_req & init_done. There is no backpressure in RUN; every request is granted the same cycle.
- Port A write: each byte i with a_be[i]=1 takes a_wdata[8i+7:8i]; other bytes are unchanged. a_be=0 is a legal no-op write.
- Responses: every granted request, read or write, produces exactly one rvalid pulse, in order.
  - For a write response, a_rdata holds its previous value.
  - rdata holds its value between rvalid pulses.
- Same-address collision (B reads the word A writes in the same cycle): B returns the old data (read-before-write). A write followed by a read of the same address on any port returns the new data.
- Back-to-back grants sustain one response per cycle per port.
- Reset mid-operation: in-flight responses are dropped (no rvalid after reset). The clear sequence restarts from address 0, including when reset arrives during CLEAR.
- Out-of-range addresses cannot occur; the address is always full-width.

## Timing
- Clear duration: init_done rises on the edge DEPTH cycles after the first cycle with reset=0. With INIT_ON_RESET=0, it rises one cycle after.
- Read latency:
  - READ_LATENCY=1: rvalid and rdata are registered one cycle after gnt.
  - READ_LATENCY=2: they appear two cycles after gnt; the extra stage is a plain register with valid.
- Writes commit on the grant edge. They are visible to a read granted on the next cycle.
- Ports A and B are fully independent in timing; there is no arbitration.

## Test plan
- Clear sequence: ADDR_WIDTH=4, preload MEM with 0xFFFFFFFF, release reset. Expect init_done=0 and gnt=0 for 16 cycles, then init_done=1. Reading all 16 words returns 0.
- Byte-enable write: A writes 0x11223344 to addr 3 with be=1111, then 0xAABBCCDD with be=0101. B reads addr 3 and gets 0x11BB33DD, with rvalid exactly READ_LATENCY cycles after gnt.
- Same-cycle collision: addr 5 holds 0x0000_0001. In one cycle, A writes 0xDEADBEEF to addr 5 and B reads addr 5. B returns 0x00000001; B's read of addr 5 on the next cycle returns 0xDEADBEEF.
- Streaming: READ_LATENCY=2, B reads addr 0..7 back-to-back after writes of data=addr*3. Expect 8 consecutive rvalid pulses returning 0,3,...,21 in order. A write response pulses a_rvalid while a_rdata stays unchanged.
- Reset mid-operation: assert reset for one cycle while 2 reads are in flight. Expect no rvalid afterwards, rdata=0, and a full 16-cycle clear before the next grant.
- INIT_ON_RESET=0: preloaded 0x12345678 at addr 2 survives reset. init_done rises one cycle after reset is released, and a read of addr 2 returns 0x12345678.
